// File: rtl/cpu_seq_pkg.sv
// Shared types and defaults for the CPU phase sequencer.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } seq_state_t;

    localparam int CNT_W_DEFAULT       = 32;
    localparam int MEM_TIMEOUT_DEFAULT = 15;

    // States in which an instruction is in flight.
    function automatic logic is_busy_state(input seq_state_t s);
        return !(s == IDLE || s == HALT || s == ERR);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter for memory handshakes. expired is high during the
// wait cycle that brings the count up to LIMIT, so the caller can leave
// the waiting state on that same edge.
module seq_wait_timer
    import cpu_seq_pkg::*;
#(
    parameter int LIMIT = MEM_TIMEOUT_DEFAULT,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [W-1:0] count;

    // Count held-request cycles, saturating at LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = inc && (count == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Optional memory-ack timeout is enabled by defining SEQ_TIMEOUT_EN; without
// it the FSM waits forever for an ack and error stays 0.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | stopped at an instruction boundary, waiting for run
//   FETCH  | imem_req high until imem_ack; ack latches IR
//   DECODE | single decode cycle
//   EXEC   | exec_en for one cycle; mem_op selects MEM or WB
//   MEM    | dmem_req high until dmem_ack
//   WB     | register write, PC load, retire count
//   HALT   | halted by instruction, only reset leaves
//   ERR    | memory ack timeout, only reset leaves
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             mem_op,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             exec_en,
    output logic             reg_we_gate,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    seq_state_t state;
    seq_state_t state_nxt;

`ifdef SEQ_TIMEOUT_EN
    logic wait_clear;
    logic wait_inc;
    logic wait_expired;

    // Timer runs only while a request is outstanding; any other state clears it,
    // which makes every entry into FETCH or MEM start from zero.
    always_comb begin
        wait_clear = 1'b1;
        wait_inc   = 1'b0;
        if (state == FETCH) begin
            wait_clear = 1'b0;
            wait_inc   = !imem_ack;
        end else if (state == MEM) begin
            wait_clear = 1'b0;
            wait_inc   = !dmem_ack;
        end
    end

    seq_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .inc     (wait_inc),
        .expired (wait_expired)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack always wins over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_nxt = DECODE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_expired) begin
                    state_nxt = ERR;
                end
`endif
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = mem_op ? MEM : WB;
            end
            MEM: begin
                if (dmem_ack) begin
                    state_nxt = WB;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_expired) begin
                    state_nxt = ERR;
                end
`endif
            end
            WB: begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else if (run) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs from the registered state; ir_we alone follows imem_ack.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_we       = 1'b0;
        exec_en     = 1'b0;
        reg_we_gate = 1'b0;
        pc_we       = 1'b0;
        halted      = 1'b0;
        error       = 1'b0;
        busy        = is_busy_state(state);
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            EXEC: begin
                exec_en = 1'b1;
            end
            MEM: begin
                dmem_req = 1'b1;
            end
            WB: begin
                reg_we_gate = 1'b1;
                pc_we       = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            ERR: begin
`ifdef SEQ_TIMEOUT_EN
                error = 1'b1;
`else
                error = 1'b0;
`endif
            end
            default: begin
                busy = is_busy_state(state);
            end
        endcase
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (state == WB) begin
            instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: vector table, directed corner sequences and
// random stimulus against a phase-level reference model.
module tb_cpu_phase_sequencer;

    localparam int CW = 4;
    localparam int TO = 15;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_MEM = 4, P_WB = 5, P_HALT = 6, P_ERR = 7;

    logic clk = 1'b0;
    logic reset, run, halt_req, mem_op, imem_ack, dmem_ack;
    logic imem_req, dmem_req, ir_we, exec_en, reg_we_gate, pc_we, busy, halted, error;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    cpu_phase_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .mem_op(mem_op),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_we(ir_we), .exec_en(exec_en), .reg_we_gate(reg_we_gate), .pc_we(pc_we),
        .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
    );

    int checks = 0;
    int errors = 0;

    // reference model: instruction phase, retire count, wait cycles in current request
    int m_ph = P_IDLE;
    int m_cnt = 0;
    int m_wait = 0;

    typedef struct {
        logic       run, mem_op, imem_ack, dmem_ack, halt_req;
        logic [6:0] exp;   // imem_req dmem_req ir_we exec_en reg_we_gate pc_we busy
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".imem_req"},    32'(imem_req),    32'(m_ph == P_FETCH));
        chk({tag, ".dmem_req"},    32'(dmem_req),    32'(m_ph == P_MEM));
        chk({tag, ".ir_we"},       32'(ir_we),       32'(m_ph == P_FETCH && imem_ack));
        chk({tag, ".exec_en"},     32'(exec_en),     32'(m_ph == P_EXEC));
        chk({tag, ".reg_we_gate"}, 32'(reg_we_gate), 32'(m_ph == P_WB));
        chk({tag, ".pc_we"},       32'(pc_we),       32'(m_ph == P_WB));
        chk({tag, ".busy"},        32'(busy),        32'(m_ph >= P_FETCH && m_ph <= P_WB));
        chk({tag, ".halted"},      32'(halted),      32'(m_ph == P_HALT));
        chk({tag, ".error"},       32'(error),       32'(m_ph == P_ERR));
        chk({tag, ".instr_count"}, 32'(instr_count), 32'(m_cnt));
    endtask

    task automatic model_clock();
        case (m_ph)
            P_IDLE: if (run) begin m_ph = P_FETCH; m_wait = 0; end
            P_FETCH: begin
                if (imem_ack) m_ph = P_DECODE;
                else begin
                    m_wait++;
                    if (TIMEOUT_ON && m_wait >= TO) m_ph = P_ERR;
                end
            end
            P_DECODE: m_ph = P_EXEC;
            P_EXEC: begin
                m_ph = mem_op ? P_MEM : P_WB;
                m_wait = 0;
            end
            P_MEM: begin
                if (dmem_ack) m_ph = P_WB;
                else begin
                    m_wait++;
                    if (TIMEOUT_ON && m_wait >= TO) m_ph = P_ERR;
                end
            end
            P_WB: begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_wait = 0;
                if (halt_req) m_ph = P_HALT;
                else if (run) m_ph = P_FETCH;
                else m_ph = P_IDLE;
            end
            default: ;
        endcase
    endtask

    // one clock: check mid-cycle, advance model, return at the next falling edge
    task automatic tick(input string tag, input bit do_check);
        #1;
        if (do_check) check_outputs(tag);
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic m, input logic ia, input logic da, input logic h);
        run = r; mem_op = m; imem_ack = ia; dmem_ack = da; halt_req = h;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_ph = P_IDLE; m_cnt = 0; m_wait = 0;
    endtask

    task automatic run_until(input int ph, input int max_cycles, input string tag);
        int n = 0;
        while (m_ph != ph && n < max_cycles) begin
            tick(tag, 1'b1);
            n++;
        end
        chk({tag, ".reached_phase"}, 32'(m_ph == ph), 32'd1);
    endtask

    initial begin
        int pc_n, first_pc, last_pc, req_n;

        set_in(0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        check_outputs("reset");
        @(negedge clk);
        do_reset();

        // table: fetch with one wait, mem access with three waits, then stop
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000001});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1010001});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0000001});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001001});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0100001});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100001});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0100001});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0100001});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000111});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1010001});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000001});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000111});
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0000000});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000});
        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].run, vq[i].mem_op, vq[i].imem_ack, vq[i].dmem_ack, vq[i].halt_req);
            #1;
            chk($sformatf("vec%0d", i),
                32'({imem_req, dmem_req, ir_we, exec_en, reg_we_gate, pc_we, busy}),
                32'(vq[i].exp));
            model_clock();
            @(posedge clk);
            @(negedge clk);
        end
        chk("vec.instr_count", 32'(instr_count), 32'd2);

        // back-to-back non-mem instructions: pc_we every 4 cycles
        do_reset();
        set_in(1, 0, 1, 1, 0);
        tick("a.idle", 1'b1);
        pc_n = 0; first_pc = 0; last_pc = 0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (pc_we) begin
                pc_n++;
                if (first_pc == 0) first_pc = c;
                last_pc = c;
            end
            #0;
            check_outputs("a");
            model_clock();
            @(posedge clk);
            @(negedge clk);
        end
        chk("a.pc_we_pulses", 32'(pc_n), 32'd3);
        chk("a.first_pc_we", 32'(first_pc), 32'd4);
        chk("a.last_pc_we", 32'(last_pc), 32'd12);
        chk("a.instr_count", 32'(instr_count), 32'd3);

        // async reset while waiting in MEM
        do_reset();
        set_in(1, 0, 1, 1, 0);
        run_until(P_WB, 10, "b.first");
        tick("b.wb", 1'b1);
        mem_op = 1'b1;
        run_until(P_MEM, 10, "b.tomem");
        dmem_ack = 1'b0;
        tick("b.memwait", 1'b1);
        #1;
        chk("b.dmem_req_before", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("b.outs_in_reset",
            32'({imem_req, dmem_req, ir_we, exec_en, reg_we_gate, pc_we, busy, halted, error}), 32'd0);
        chk("b.count_in_reset", 32'(instr_count), 32'd0);
        m_ph = P_IDLE; m_cnt = 0; m_wait = 0;
        @(negedge clk);
        reset = 1'b0;
        set_in(1, 0, 0, 0, 0);
        tick("b.idle", 1'b1);
        #1;
        chk("b.imem_req_after", 32'(imem_req), 32'd1);
        tick("b.fetch", 1'b1);

        // halt: ignored in DECODE, taken in WB over run
        do_reset();
        set_in(1, 0, 1, 1, 0);
        run_until(P_DECODE, 10, "c.todecode");
        halt_req = 1'b1;
        tick("c.decode_halt", 1'b1);
        halt_req = 1'b0;
        run_until(P_WB, 10, "c.towb1");
        tick("c.wb1", 1'b1);
        #1;
        chk("c.refetch", 32'(imem_req), 32'd1);
        run_until(P_WB, 10, "c.towb2");
        halt_req = 1'b1;
        tick("c.wb2", 1'b1);
        halt_req = 1'b0;
        #1;
        chk("c.halted", 32'(halted), 32'd1);
        req_n = 0;
        for (int c = 0; c < 20; c++) begin
            imem_ack = 1'(c % 2);
            #1;
            req_n += int'(imem_req) + int'(dmem_req);
            tick("c.halt", 1'b1);
        end
        chk("c.req_while_halted", 32'(req_n), 32'd0);
        chk("c.count", 32'(instr_count), 32'd2);

        // instruction fetch never acknowledged
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick("d.idle", 1'b1);
        req_n = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            req_n += int'(imem_req);
            tick("d.wait", 1'b1);
        end
        chk("d.req_cycles", 32'(req_n), 32'd15);
        #1;
        if (TIMEOUT_ON) begin
            chk("d.error", 32'(error), 32'd1);
            chk("d.imem_req", 32'(imem_req), 32'd0);
            chk("d.busy", 32'(busy), 32'd0);
        end else begin
            chk("d.error", 32'(error), 32'd0);
            chk("d.imem_req", 32'(imem_req), 32'd1);
        end
        for (int c = 0; c < 10; c++) tick("d.after", 1'b1);

        // counter wrap after 16 instructions, then stop requested in DECODE
        do_reset();
        set_in(1, 0, 1, 1, 0);
        tick("e.idle", 1'b1);
        for (int c = 0; c < 64; c++) tick("e.run", 1'b1);
        chk("e.wrapped", 32'(instr_count), 32'd0);
        tick("e.fetch", 1'b1);
        run = 1'b0;
        for (int c = 0; c < 3; c++) tick("e.drain", 1'b1);
        #1;
        chk("e.idle_busy", 32'(busy), 32'd0);
        chk("e.idle_count", 32'(instr_count), 32'd1);
        for (int c = 0; c < 3; c++) tick("e.stay", 1'b1);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_ph == P_HALT || m_ph == P_ERR) begin
                do_reset();
            end else begin
                run      = ($urandom_range(0, 9) != 0);
                mem_op   = 1'($urandom_range(0, 1));
                halt_req = ($urandom_range(0, 24) == 0);
                imem_ack = ($urandom_range(0, 2) != 0) || (m_wait >= 5);
                dmem_ack = ($urandom_range(0, 2) != 0) || (m_wait >= 5);
                tick("rnd", 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
